// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation (plain^exponent mod modulus), left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier. Define RSA_CONST_TIME_EN for fixed latency.
module rsa_modexp_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             rst_rsa,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             eoc,
    output logic             busy,
    output logic             err
);
    // state | meaning
    // IDLE  | waiting for first enabled edge, then capture operands
    // SQR   | acc = acc*acc mod M, one multiplier bit per enabled cycle
    // MUL   | acc = acc*P mod M, one multiplier bit per enabled cycle
    // DONE  | result valid, eoc held until soft or hard reset
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state;
    logic [WIDTH-1:0] p_reg, e_reg, m_reg, acc, t;
    logic [IW-1:0]    idx, cnt;

    logic [WIDTH:0]   m_ext, dbl, dbl_red, sum;
    logic [WIDTH-1:0] mul_y, t_next, new_acc;
    logic             go_mul;

    // One interleaved step: double with one conditional subtract, then add with one.
    always_comb begin
        m_ext   = {1'b0, m_reg};
        mul_y   = (state == MUL) ? p_reg : acc;
        dbl     = {t, 1'b0};
        dbl_red = (dbl >= m_ext) ? dbl - m_ext : dbl;
        sum     = mul_y[cnt] ? dbl_red + {1'b0, acc} : dbl_red;
        t_next  = (sum >= m_ext) ? WIDTH'(sum - m_ext) : WIDTH'(sum);
    end

    // What a finishing SQR/MUL phase writes back and where it goes next.
    always_comb begin
        new_acc = t_next;
        go_mul  = 1'b0;
        if (state == SQR) begin
`ifdef RSA_CONST_TIME_EN
            go_mul = 1'b1;
`else
            go_mul = e_reg[idx];
`endif
        end else begin
`ifdef RSA_CONST_TIME_EN
            new_acc = e_reg[idx] ? t_next : acc;
`else
            new_acc = t_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb || !rst_rsa) begin
            state  <= IDLE;
            p_reg  <= '0;
            e_reg  <= '0;
            m_reg  <= '0;
            acc    <= '0;
            t      <= '0;
            idx    <= '0;
            cnt    <= '0;
            result <= '0;
            eoc    <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    p_reg <= plain;
                    e_reg <= exponent;
                    m_reg <= modulus;
                    if (modulus < TWO || plain >= modulus) begin
                        state <= DONE;
                        eoc   <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        acc   <= ONE;
                        t     <= '0;
                        idx   <= IDX_MAX;
                        cnt   <= IDX_MAX;
                        busy  <= 1'b1;
                        state <= SQR;
                    end
                end
                SQR, MUL: if (en) begin
                    if (cnt != '0) begin
                        t   <= t_next;
                        cnt <= cnt - 1'b1;
                    end else begin
                        t   <= '0;
                        cnt <= IDX_MAX;
                        acc <= new_acc;
                        if (go_mul) begin
                            state <= MUL;
                        end else if (idx == '0) begin
                            state  <= DONE;
                            result <= new_acc;
                            eoc    <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SQR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Self-checking bench for rsa_modexp_unit: directed scenarios plus random operands
// against an arithmetic reference model.
module tb_rsa_modexp_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstb, en, rst_rsa;
    logic [W-1:0] plain, exponent, modulus;
    logic [W-1:0] result;
    logic         eoc, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    rsa_modexp_unit #(.WIDTH(W)) dut (
        .clk(clk), .rstb(rstb), .en(en), .rst_rsa(rst_rsa),
        .plain(plain), .exponent(exponent), .modulus(modulus),
        .result(result), .eoc(eoc), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_modexp(int p, int e, int m);
        longint r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (((e >> i) & 1) == 1) r = (r * p) % m;
        end
        return W'(r);
    endfunction

    function automatic int ref_lat(int e);
`ifdef RSA_CONST_TIME_EN
        return 1 + 2 * W * W;
`else
        return 1 + W * (W + $countones(e[W-1:0]));
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Soft-reset, apply operands, release; the next edge is the capture edge.
    task automatic start_op(input int p, input int e, input int m);
        rst_rsa = 1'b0;
        tick();
        plain    = W'(p);
        exponent = W'(e);
        modulus  = W'(m);
        rst_rsa  = 1'b1;
        en       = 1'b1;
    endtask

    // Advance until eoc; edges counts from the capture edge (-1 on timeout).
    task automatic run_to_eoc(input int already, output int edges, output int busy_low);
        edges    = already;
        busy_low = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            edges++;
            if (eoc) return;
            if (!busy) busy_low++;
        end
        edges = -1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; rst_rsa = 1'b1; en = 1'b1;
        plain = 8'd7; exponent = 8'd13; modulus = 8'd33;
        repeat (3) tick();
        n_cmp++;
        if ({result, eoc, busy, err} !== {8'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset outputs: got result=%0d eoc=%b busy=%b err=%b, want all 0", result, eoc, busy, err);
        end
        rstb = 1'b1;
    endtask

    task automatic test_directed();
        int edges, bl;
        start_op(7, 13, 33);
        tick();
        n_cmp++;
        if (busy !== 1'b1 || eoc !== 1'b0) begin
            n_bad++;
            $display("FAIL directed busy at edge1: got busy=%b eoc=%b, want 1/0", busy, eoc);
        end
        run_to_eoc(1, edges, bl);
        n_cmp++;
        if (result !== 8'd13 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL directed result: got %0d err=%b, want 13 err=0", result, err);
        end
        n_cmp++;
        if (edges !== ref_lat(13)) begin
            n_bad++;
            $display("FAIL directed latency: got %0d, want %0d", edges, ref_lat(13));
        end
        n_cmp++;
        if (bl !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL directed busy: got %0d idle samples, busy_at_eoc=%b, want 0/0", bl, busy);
        end
    endtask

    task automatic test_exp_zero();
        int edges, bl;
        start_op(5, 0, 11);
        run_to_eoc(0, edges, bl);
        n_cmp++;
        if (result !== 8'd1 || edges !== ref_lat(0)) begin
            n_bad++;
            $display("FAIL exp_zero: got result=%0d edges=%0d, want 1/%0d", result, edges, ref_lat(0));
        end
        start_op(0, 5, 11);
        run_to_eoc(0, edges, bl);
        n_cmp++;
        if (result !== 8'd0 || err !== 1'b0 || edges !== ref_lat(5)) begin
            n_bad++;
            $display("FAIL base_zero: got result=%0d err=%b edges=%0d, want 0/0/%0d", result, err, edges, ref_lat(5));
        end
    endtask

    task automatic test_invalid();
        int edges, bl;
        int pv[2] = '{0, 40};
        int mv[2] = '{1, 33};
        for (int k = 0; k < 2; k++) begin
            start_op(pv[k], 3, mv[k]);
            run_to_eoc(0, edges, bl);
            n_cmp++;
            if (edges !== 1 || err !== 1'b1 || result !== 8'd0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL invalid P=%0d M=%0d: got edges=%0d err=%b result=%0d busy=%b, want 1/1/0/0",
                         pv[k], mv[k], edges, err, result, busy);
            end
        end
    endtask

    task automatic test_stall();
        int edges, bl;
        start_op(7, 13, 33);
        repeat (5) tick();
        en = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (busy !== 1'b1 || eoc !== 1'b0) begin
            n_bad++;
            $display("FAIL stall hold: got busy=%b eoc=%b, want 1/0", busy, eoc);
        end
        en = 1'b1;
        run_to_eoc(15, edges, bl);
        n_cmp++;
        if (result !== 8'd13 || edges !== ref_lat(13) + 10) begin
            n_bad++;
            $display("FAIL stall: got result=%0d edges=%0d, want 13/%0d", result, edges, ref_lat(13) + 10);
        end
    endtask

    task automatic test_soft_reset();
        int edges, bl;
        start_op(7, 13, 33);
        repeat (40) tick();
        rst_rsa = 1'b0;
        tick();
        n_cmp++;
        if ({result, eoc, busy, err} !== {8'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL soft_reset clear: got result=%0d eoc=%b busy=%b err=%b, want all 0", result, eoc, busy, err);
        end
        plain = 8'd3; exponent = 8'd4; modulus = 8'd7;
        rst_rsa = 1'b1;
        run_to_eoc(0, edges, bl);
        n_cmp++;
        if (result !== 8'd4 || edges !== ref_lat(4)) begin
            n_bad++;
            $display("FAIL soft_reset rerun: got result=%0d edges=%0d, want 4/%0d", result, edges, ref_lat(4));
        end
    endtask

    task automatic test_done_hold();
        int edges, bl;
        start_op(7, 13, 33);
        run_to_eoc(0, edges, bl);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            plain = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
            tick();
            n_cmp++;
            if (result !== 8'd13 || eoc !== 1'b1) begin
                n_bad++;
                $display("FAIL done_hold cycle %0d: got result=%0d eoc=%b, want 13/1", i, result, eoc);
            end
        end
        rst_rsa = 1'b0;
        tick();
        n_cmp++;
        if (result !== 8'd0 || eoc !== 1'b0) begin
            n_bad++;
            $display("FAIL done_release: got result=%0d eoc=%b, want 0/0", result, eoc);
        end
        rst_rsa = 1'b1;
    endtask

    task automatic test_random();
        int edges, bl, m, p, e;
        logic [W-1:0] exp_r;
        for (int n = 0; n < 20; n++) begin
            m = $urandom_range(2, 255);
            p = $urandom_range(0, m - 1);
            e = $urandom_range(0, 255);
            exp_r = ref_modexp(p, e, m);
            start_op(p, e, m);
            run_to_eoc(0, edges, bl);
            n_cmp++;
            if (result !== exp_r || err !== 1'b0 || edges !== ref_lat(e)) begin
                n_bad++;
                $display("FAIL random P=%0d E=%0d M=%0d: got result=%0d err=%b edges=%0d, want %0d/0/%0d",
                         p, e, m, result, err, edges, exp_r, ref_lat(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exp_zero();
        test_invalid();
        test_stall();
        test_soft_reset();
        test_done_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
